// File: rtl/ram_pkg.sv
// Shared definitions for the RAM port arbiter: RAM geometry, command
// encodings, the command record and round-robin pointer helpers.
package ram_pkg;

    localparam int RAM_ADDR_W = 10;
    localparam int RAM_DATA_W = 32;

    // Command encodings; CMD_WR also matches the polarity of ram_wr_rdn.
    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    typedef struct packed {
        logic                  wr;
        logic [RAM_ADDR_W-1:0] addr;
        logic [RAM_DATA_W-1:0] wdata;
    } ram_cmd_t;

    // Width of a pointer that indexes n requesters (at least one bit).
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Next round-robin position after idx, wrapping explicitly at n so a
    // non-power-of-two requester count never walks into unused codes.
    function automatic int rr_next(input int idx, input int n);
        if (idx + 1 >= n) begin
            return 0;
        end
        return idx + 1;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side bus of the RAM port arbiter.
//
// Handshake: a command on slice i transfers in the cycle where
// req_valid[i] and req_ready[i] are both high at the rising clock edge.
// The requester keeps req_valid[i], req_wr[i] and its address/data slices
// stable until that transfer, but may withdraw req_valid[i] before it is
// granted. req_ready is one-hot or zero. Read responses are a one-cycle
// rsp_valid[i] pulse with rsp_rdata; they cannot be stalled.
interface ram_port_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_wr;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;

    // Requesters drive commands and receive grants/responses.
    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    // The arbiter receives commands and drives grants/responses.
    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at
// or after ptr, wrapping around to index 0.
module rr_arbiter
    import ram_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = ptr_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);

    logic found;

    // Two passes: first the requests at or above ptr, then the wrapped-around
    // ones below it; the first hit wins, which gives rotating priority.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (j >= int'(ptr))) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = PW'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = PW'(j);
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous RAM between NUM_REQ requesters.
// Cycle G: round-robin grant (combinational). Cycle G+1: command registered
// onto the RAM pins. Cycle G+2: the RAM's registered read data is returned
// to the tagged requester as a one-cycle rsp_valid pulse.
module ram_port_arbiter
    import ram_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = RAM_ADDR_W,
    parameter int DATA_W  = RAM_DATA_W,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    ram_port_arbiter_if.slave  bus,
    output logic               ram_rstn,
    output logic               ram_en,
    output logic               ram_wr_rdn,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [DATA_W-1:0]  ram_data_wr,
    input  logic [DATA_W-1:0]  ram_data_rd,
    output logic [PTR_W-1:0]   dbg_rr_ptr_o
);

    // Arbitration
    logic [NUM_REQ-1:0] req_live;
    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               accept;

    // Payload of the granted requester
    logic               sel_wr;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    // Round-robin pointer
    logic [PTR_W-1:0]   ptr_q, ptr_d;

    // Issue stage: drives the RAM pins directly
    logic               ram_en_q, ram_en_d;
    logic               ram_wr_rdn_q, ram_wr_rdn_d;
    logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]  ram_data_wr_q, ram_data_wr_d;
    logic               issue_rd_q, issue_rd_d;
    logic [PTR_W-1:0]   issue_tag_q, issue_tag_d;

    // Response stage: RAM read data is valid while rsp_rd_q is set
    logic               rsp_rd_q, rsp_rd_d;
    logic [PTR_W-1:0]   rsp_tag_q, rsp_tag_d;

    // Requests are masked during reset so no grant can appear while rst is high.
    assign req_live = bus.req_valid & {NUM_REQ{~rst}};

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PTR_W)
    ) u_rr_arbiter (
        .req       (req_live),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign accept        = |grant;
    assign bus.req_ready = grant;

    // Pick the command fields of the granted requester out of the flat buses.
    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_wr    = bus.req_wr[i];
                sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next state of the pointer and both pipeline stages; the address/data
    // pins hold their last value when no command is issued.
    always_comb begin
        ptr_d         = ptr_q;
        ram_en_d      = accept;
        ram_wr_rdn_d  = ram_wr_rdn_q;
        ram_addr_d    = ram_addr_q;
        ram_data_wr_d = ram_data_wr_q;
        issue_rd_d    = 1'b0;
        issue_tag_d   = issue_tag_q;
        rsp_rd_d      = issue_rd_q;
        rsp_tag_d     = issue_tag_q;
        if (accept) begin
            ptr_d         = PTR_W'(rr_next(int'(grant_idx), NUM_REQ));
            ram_wr_rdn_d  = (sel_wr == CMD_WR);
            ram_addr_d    = sel_addr;
            ram_data_wr_d = sel_wdata;
            issue_rd_d    = (sel_wr == CMD_RD);
            issue_tag_d   = grant_idx;
        end
    end

    // State registers; reset drops every in-flight command.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q         <= '0;
            ram_en_q      <= 1'b0;
            ram_wr_rdn_q  <= 1'b0;
            ram_addr_q    <= '0;
            ram_data_wr_q <= '0;
            issue_rd_q    <= 1'b0;
            issue_tag_q   <= '0;
            rsp_rd_q      <= 1'b0;
            rsp_tag_q     <= '0;
        end else begin
            ptr_q         <= ptr_d;
            ram_en_q      <= ram_en_d;
            ram_wr_rdn_q  <= ram_wr_rdn_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_wr_q <= ram_data_wr_d;
            issue_rd_q    <= issue_rd_d;
            issue_tag_q   <= issue_tag_d;
            rsp_rd_q      <= rsp_rd_d;
            rsp_tag_q     <= rsp_tag_d;
        end
    end

    // Decode the response tag into a one-hot pulse for the owning requester.
    always_comb begin
        bus.rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.rsp_valid[i] = rsp_rd_q && (rsp_tag_q == PTR_W'(i));
        end
    end

    assign bus.rsp_rdata = rsp_rd_q ? ram_data_rd : '0;

    assign ram_rstn     = ~rst;
    assign ram_en       = ram_en_q;
    assign ram_wr_rdn   = ram_wr_rdn_q;
    assign ram_addr     = ram_addr_q;
    assign ram_data_wr  = ram_data_wr_q;
    assign dbg_rr_ptr_o = ptr_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed vector table, reset corner case, then
// randomized traffic checked against a cycle-level transaction model.
module tb_ram_port_arbiter;
    import ram_pkg::*;

    localparam int N  = 2;
    localparam int AW = RAM_ADDR_W;
    localparam int DW = RAM_DATA_W;
    localparam int PW = ptr_width(N);

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          ram_rstn, ram_en, ram_wr_rdn;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data_wr, ram_data_rd;
    logic [PW-1:0] dbg_ptr;

    always #5 clk = ~clk;

    ram_port_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .ram_rstn     (ram_rstn),
        .ram_en       (ram_en),
        .ram_wr_rdn   (ram_wr_rdn),
        .ram_addr     (ram_addr),
        .ram_data_wr  (ram_data_wr),
        .ram_data_rd  (ram_data_rd),
        .dbg_rr_ptr_o (dbg_ptr)
    );

    // Single-port RAM with registered read data
    logic [DW-1:0] ram_mem [0:1023];
    logic [DW-1:0] ram_q;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wr_rdn) ram_mem[ram_addr] <= ram_data_wr;
            else            ram_q <= ram_mem[ram_addr];
        end
    end
    assign ram_data_rd = ram_q;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: accepted commands in program order, responses due
    // exactly two cycles after acceptance, fairness via a rotating start index.
    typedef struct {
        int            due;
        int            idx;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [DW-1:0] m_mem [0:1023];
    int            m_ptr = 0;
    bit            m_en = 1'b0;
    logic          m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    int            cyc = 0;
    bit            mon_en = 1'b0;
    bit            mon_vld [N];
    int            mon_w;
    logic [N-1:0]  mon_g, mon_rv;
    logic [DW-1:0] mon_rd;

    always @(negedge clk) begin
        if (mon_en) begin
            for (int j = 0; j < N; j++) mon_vld[j] = bus.req_valid[j];
            mon_w = -1;
            if (!rst) begin
                for (int k = 0; k < N; k++) begin
                    if (mon_w < 0 && mon_vld[(m_ptr + k) % N]) mon_w = (m_ptr + k) % N;
                end
            end
            for (int j = 0; j < N; j++) mon_g[j] = (j == mon_w);
            check("model req_ready", 32'(bus.req_ready), 32'(mon_g));
            check("model ram_en", 32'(ram_en), 32'(m_en));
            if (m_en) begin
                check("model ram_wr_rdn", 32'(ram_wr_rdn), 32'(m_wr));
                check("model ram_addr", 32'(ram_addr), 32'(m_addr));
                if (m_wr) check("model ram_data_wr", ram_data_wr, m_wdata);
            end
            mon_rv = '0;
            mon_rd = '0;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                for (int j = 0; j < N; j++) mon_rv[j] = (j == exp_q[0].idx);
                mon_rd = exp_q[0].data;
                void'(exp_q.pop_front());
            end
            check("model rsp_valid", 32'(bus.rsp_valid), 32'(mon_rv));
            if (mon_rv != '0) check("model rsp_rdata", bus.rsp_rdata, mon_rd);
            // Advance the model across the coming clock edge.
            if (rst) begin
                exp_q.delete();
                m_ptr = 0;
                m_en  = 1'b0;
            end else if (mon_w >= 0) begin
                for (int j = 0; j < N; j++) begin
                    if (j == mon_w) begin
                        m_wr    = bus.req_wr[j];
                        m_addr  = bus.req_addr[j*AW +: AW];
                        m_wdata = bus.req_wdata[j*DW +: DW];
                    end
                end
                m_en = 1'b1;
                if (m_wr) m_mem[m_addr] = m_wdata;
                else      exp_q.push_back('{cyc + 2, mon_w, m_mem[m_addr]});
                m_ptr = (mon_w + 1) % N;
            end else begin
                m_en = 1'b0;
            end
            cyc++;
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [N-1:0]  valid;
        ram_cmd_t      c0;
        ram_cmd_t      c1;
        logic [N-1:0]  e_ready;
        logic          e_en;
        logic [N-1:0]  e_rsp;
        logic [DW-1:0] e_rdata;
    } vec_t;

    vec_t tbl[$];

    function automatic ram_cmd_t cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ram_cmd_t c;
        c.wr    = wr;
        c.addr  = a;
        c.wdata = d;
        return c;
    endfunction

    function automatic vec_t mk(input logic [N-1:0] v, input ram_cmd_t c0, input ram_cmd_t c1,
                                input logic [N-1:0] rdy, input logic en,
                                input logic [N-1:0] rsp, input logic [DW-1:0] rd);
        vec_t x;
        x.valid = v;   x.c0 = c0;   x.c1 = c1;
        x.e_ready = rdy; x.e_en = en; x.e_rsp = rsp; x.e_rdata = rd;
        return x;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [N-1:0] v, input ram_cmd_t c0, input ram_cmd_t c1);
        bus.req_valid          = v;
        bus.req_wr             = {c1.wr, c0.wr};
        bus.req_addr           = {c1.addr, c0.addr};
        bus.req_wdata          = {c1.wdata, c0.wdata};
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    ram_cmd_t idle_c;
    ram_cmd_t r0_c, r1_c;
    logic [N-1:0] acc;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram_mem[i] = '0;
            m_mem[i]   = '0;
        end
        ram_q  = '0;
        idle_c = cmd(1'b0, '0, '0);

        // ---- reset state, with both requesters already asserting valid ----
        rst = 1'b1;
        drive(2'b11, idle_c, idle_c);
        next_cycle();
        mon_en = 1'b1;
        @(negedge clk);
        check("reset req_ready", 32'(bus.req_ready), 32'h0);
        check("reset ram_en", 32'(ram_en), 32'h0);
        check("reset ram_wr_rdn", 32'(ram_wr_rdn), 32'h0);
        check("reset ram_addr", 32'(ram_addr), 32'h0);
        check("reset ram_data_wr", ram_data_wr, 32'h0);
        check("reset rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("reset rsp_rdata", bus.rsp_rdata, 32'h0);
        check("reset ram_rstn", 32'(ram_rstn), 32'h0);
        check("reset rr_ptr", 32'(dbg_ptr), 32'h0);
        next_cycle();
        rst = 1'b0;
        drive(2'b00, idle_c, idle_c);

        // Single read after write
        tbl.push_back(mk(2'b01, cmd(1, 10'd5, 32'hDEADBEEF), idle_c, 2'b01, 0, 2'b00, 0));
        tbl.push_back(mk(2'b10, idle_c, cmd(0, 10'd5, 0), 2'b10, 1, 2'b00, 0));
        tbl.push_back(mk(2'b00, idle_c, idle_c, 2'b00, 1, 2'b00, 0));
        tbl.push_back(mk(2'b00, idle_c, idle_c, 2'b00, 0, 2'b10, 32'hDEADBEEF));
        // Contention: preload, then both read every cycle
        tbl.push_back(mk(2'b01, cmd(1, 10'h10, 32'h11110010), idle_c, 2'b01, 0, 2'b00, 0));
        tbl.push_back(mk(2'b10, idle_c, cmd(1, 10'h20, 32'h22220020), 2'b10, 1, 2'b00, 0));
        r0_c = cmd(0, 10'h10, 0);
        r1_c = cmd(0, 10'h20, 0);
        tbl.push_back(mk(2'b11, r0_c, r1_c, 2'b01, 1, 2'b00, 0));
        tbl.push_back(mk(2'b11, r0_c, r1_c, 2'b10, 1, 2'b00, 0));
        tbl.push_back(mk(2'b11, r0_c, r1_c, 2'b01, 1, 2'b01, 32'h11110010));
        tbl.push_back(mk(2'b11, r0_c, r1_c, 2'b10, 1, 2'b10, 32'h22220020));
        tbl.push_back(mk(2'b00, idle_c, idle_c, 2'b00, 1, 2'b01, 32'h11110010));
        tbl.push_back(mk(2'b00, idle_c, idle_c, 2'b00, 0, 2'b10, 32'h22220020));
        // Write then read of the same address on the next cycle
        tbl.push_back(mk(2'b01, cmd(1, 10'h3FF, 32'h12345678), idle_c, 2'b01, 0, 2'b00, 0));
        tbl.push_back(mk(2'b10, idle_c, cmd(0, 10'h3FF, 0), 2'b10, 1, 2'b00, 0));
        tbl.push_back(mk(2'b00, idle_c, idle_c, 2'b00, 1, 2'b00, 0));
        tbl.push_back(mk(2'b00, idle_c, idle_c, 2'b00, 0, 2'b10, 32'h12345678));
        // Boundary addresses 0 and 1023
        tbl.push_back(mk(2'b01, cmd(1, 10'h000, 32'hA5A5A5A5), idle_c, 2'b01, 0, 2'b00, 0));
        tbl.push_back(mk(2'b10, idle_c, cmd(1, 10'h3FF, 32'h5A5A5A5A), 2'b10, 1, 2'b00, 0));
        tbl.push_back(mk(2'b01, cmd(0, 10'h000, 0), idle_c, 2'b01, 1, 2'b00, 0));
        tbl.push_back(mk(2'b10, idle_c, cmd(0, 10'h3FF, 0), 2'b10, 1, 2'b00, 0));
        tbl.push_back(mk(2'b00, idle_c, idle_c, 2'b00, 1, 2'b01, 32'hA5A5A5A5));
        tbl.push_back(mk(2'b00, idle_c, idle_c, 2'b00, 0, 2'b10, 32'h5A5A5A5A));
        // Leave the pointer at 1, idle ten cycles, then contend
        tbl.push_back(mk(2'b01, cmd(0, 10'h000, 0), idle_c, 2'b01, 0, 2'b00, 0));
        tbl.push_back(mk(2'b00, idle_c, idle_c, 2'b00, 1, 2'b00, 0));
        tbl.push_back(mk(2'b00, idle_c, idle_c, 2'b00, 0, 2'b01, 32'hA5A5A5A5));
        for (int i = 0; i < 8; i++) tbl.push_back(mk(2'b00, idle_c, idle_c, 2'b00, 0, 2'b00, 0));
        r0_c = cmd(0, 10'h000, 0);
        r1_c = cmd(0, 10'h3FF, 0);
        tbl.push_back(mk(2'b11, r0_c, r1_c, 2'b10, 0, 2'b00, 0));
        tbl.push_back(mk(2'b11, r0_c, r1_c, 2'b01, 1, 2'b00, 0));
        tbl.push_back(mk(2'b00, idle_c, idle_c, 2'b00, 1, 2'b10, 32'h5A5A5A5A));
        tbl.push_back(mk(2'b00, idle_c, idle_c, 2'b00, 0, 2'b01, 32'hA5A5A5A5));
        tbl.push_back(mk(2'b00, idle_c, idle_c, 2'b00, 0, 2'b00, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].valid, tbl[i].c0, tbl[i].c1);
            @(negedge clk);
            check($sformatf("vec%0d req_ready", i), 32'(bus.req_ready), 32'(tbl[i].e_ready));
            check($sformatf("vec%0d ram_en", i), 32'(ram_en), 32'(tbl[i].e_en));
            check($sformatf("vec%0d rsp_valid", i), 32'(bus.rsp_valid), 32'(tbl[i].e_rsp));
            if (tbl[i].e_rsp != '0) check($sformatf("vec%0d rsp_rdata", i), bus.rsp_rdata, tbl[i].e_rdata);
            next_cycle();
        end

        // ---- reset while a read sits in the issue stage ----
        drive(2'b01, cmd(0, 10'h10, 0), idle_c);
        @(negedge clk);
        check("rstmid grant", 32'(bus.req_ready), 32'h1);
        next_cycle();
        rst = 1'b1;
        drive(2'b00, idle_c, idle_c);
        @(negedge clk);
        check("rstmid issue ram_en", 32'(ram_en), 32'h1);
        check("rstmid no ready in rst", 32'(bus.req_ready), 32'h0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rstmid ram_en after", 32'(ram_en), 32'h0);
        check("rstmid no rsp", 32'(bus.rsp_valid), 32'h0);
        check("rstmid rr_ptr", 32'(dbg_ptr), 32'h0);
        check("rstmid ram_rstn", 32'(ram_rstn), 32'h1);
        next_cycle();
        drive(2'b11, cmd(0, 10'h20, 0), cmd(0, 10'h3FF, 0));
        @(negedge clk);
        check("rstmid contended grant", 32'(bus.req_ready), 32'h1);
        next_cycle();
        drive(2'b00, idle_c, idle_c);
        repeat (4) next_cycle();

        // ---- randomized traffic against the model ----
        acc = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!bus.req_valid[i] || acc[i]) begin
                    if ($urandom_range(0, 99) < 60) begin
                        bus.req_valid[i]            = 1'b1;
                        bus.req_wr[i]               = 1'($urandom_range(0, 1));
                        bus.req_addr[i*AW +: AW]    = ($urandom_range(0, 19) == 0) ? 10'h3FF
                                                      : 10'($urandom_range(0, 7));
                        bus.req_wdata[i*DW +: DW]   = $urandom;
                    end else begin
                        bus.req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 99) < 5) begin
                    bus.req_valid[i] = 1'b0;
                end
            end
            rst = ($urandom_range(0, 199) == 0);
            @(negedge clk);
            acc = bus.req_valid & bus.req_ready;
            next_cycle();
        end
        rst = 1'b0;
        drive(2'b00, idle_c, idle_c);
        repeat (5) next_cycle();
        check("drain pending responses", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
